// File: rtl/fp16_result_packer_pkg.sv
// Shared constants and types for the half-precision result packer.
package fp16_result_packer_pkg;

    localparam int unsigned FRAC_W    = 10;
    localparam int unsigned EXP_OUT_W = 5;
    localparam int unsigned EXP_IN_W  = 7;
    localparam int unsigned MANT_W    = FRAC_W + 4;
    // One extra bit so exponent steps can never wrap.
    localparam int unsigned EXP_INT_W = EXP_IN_W + 1;

    localparam int unsigned BIAS = 15;

    localparam logic signed [EXP_INT_W-1:0] EXP_MAX = EXP_INT_W'(31);
    localparam logic signed [EXP_INT_W-1:0] EXP_ONE = EXP_INT_W'(1);

    // Mantissa field positions.
    localparam int unsigned MANT_CARRY    = 13;
    localparam int unsigned MANT_HIDDEN   = 12;
    localparam int unsigned MANT_FRAC_MSB = 11;
    localparam int unsigned MANT_FRAC_LSB = 2;
    localparam int unsigned MANT_GUARD    = 1;
    localparam int unsigned MANT_STICKY   = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNorm = 2'd1,
        StRnd  = 2'd2,
        StDone = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_result_packer_round_rne.sv
// Round-to-nearest-even on a normalised {hidden, frac, guard, sticky} mantissa.
module fp16_round_rne
    import fp16_result_packer_pkg::*;
(
    input  logic              i_hidden,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_guard,
    input  logic              i_sticky,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_hidden,
    output logic              o_carry,
    output logic              o_inexact
);

    logic            w_round;
    logic [FRAC_W:0] w_sum;

    assign w_round   = i_guard & (i_sticky | i_frac[0]);
    assign w_sum     = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_round};
    // Fraction wraps to zero on carry-out, which is the value needed in both cases.
    assign o_frac    = w_sum[FRAC_W-1:0];
    // Carry past a set hidden bit bumps the exponent; past a clear one it
    // just promotes a subnormal to the smallest normal.
    assign o_carry   = i_hidden & w_sum[FRAC_W];
    assign o_hidden  = i_hidden | w_sum[FRAC_W];
    assign o_inexact = i_guard | i_sticky;

endmodule

// File: rtl/fp16_result_packer.sv
// Normalise, round and pack an unpacked FPU result into IEEE-754 binary16.
module fp16_result_packer
    import fp16_result_packer_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_clr,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_in_sign,
    input  logic [EXP_IN_W-1:0] i_in_exp,
    input  logic [MANT_W-1:0]   i_in_mant,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [15:0]         o_out_result,
    output logic                o_out_ovf,
    output logic                o_out_unf,
    output logic                o_out_inx
);

    state_t                        r_state;
    logic                          r_sign;
    logic signed [EXP_INT_W-1:0]   r_exp;
    logic [MANT_W-1:0]             r_mant;
    logic                          r_ovf_pend;
    logic                          r_zero;
    logic [15:0]                   r_result;
    logic                          r_ovf;
    logic                          r_unf;
    logic                          r_inx;

    logic [FRAC_W-1:0]             w_frac;
    logic                          w_hidden;
    logic                          w_carry;
    logic                          w_inexact;
    logic signed [EXP_INT_W-1:0]   w_exp_rnd;
    logic [EXP_OUT_W-1:0]          w_exp_enc;
    logic                          w_ovf;
    logic [15:0]                   w_result;
    logic                          w_unf;
    logic                          w_inx;

    fp16_round_rne u_round (
        .i_hidden  (r_mant[MANT_HIDDEN]),
        .i_frac    (r_mant[MANT_FRAC_MSB:MANT_FRAC_LSB]),
        .i_guard   (r_mant[MANT_GUARD]),
        .i_sticky  (r_mant[MANT_STICKY]),
        .o_frac    (w_frac),
        .o_hidden  (w_hidden),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    // Post-rounding exponent, encoding and flags, consumed in the RND state.
    always_comb begin
        w_exp_rnd = w_carry ? (r_exp + EXP_ONE) : r_exp;
        w_exp_enc = w_hidden ? w_exp_rnd[EXP_OUT_W-1:0] : '0;
        // A zero result may carry any exponent; it must never overflow.
        w_ovf     = r_ovf_pend | (!r_zero && (w_exp_rnd >= EXP_MAX));
        w_inx     = w_ovf | w_inexact;
        // Overflowed results are not tiny even if the hidden bit was clear.
        w_unf     = !r_mant[MANT_HIDDEN] & w_inexact & !w_ovf;
        w_result  = {r_sign, w_exp_enc, w_frac};
        if (w_ovf) begin
            w_result = {r_sign, 5'h1F, 10'h000};
        end
    end

    // Control FSM with the shift register, exponent counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state    <= StIdle;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_ovf_pend <= 1'b0;
            r_zero     <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_sign     <= i_in_sign;
                        r_exp      <= {i_in_exp[EXP_IN_W-1], i_in_exp};
                        r_mant     <= i_in_mant;
                        r_ovf_pend <= 1'b0;
                        r_zero     <= 1'b0;
                        r_state    <= StNorm;
                    end
                end
                StNorm: begin
                    if (r_mant[MANT_CARRY:MANT_GUARD] == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= StRnd;
                    end else if ((r_exp >= EXP_MAX) &&
                                 (r_mant[MANT_CARRY:MANT_HIDDEN] != 2'b00)) begin
                        r_ovf_pend <= 1'b1;
                        r_state    <= StRnd;
                    end else if (r_mant[MANT_CARRY] || (r_exp < EXP_ONE)) begin
                        // Old guard and old sticky both fold into the new sticky.
                        r_mant <= {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + EXP_ONE;
                    end else if (!r_mant[MANT_HIDDEN] && (r_exp > EXP_ONE)) begin
                        r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                        r_exp  <= r_exp - EXP_ONE;
                    end else begin
                        r_state <= StRnd;
                    end
                end
                StRnd: begin
                    r_result <= w_result;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                    r_inx    <= w_inx;
                    r_state  <= StDone;
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

    assign o_in_ready   = (r_state == StIdle);
    assign o_out_valid  = (r_state == StDone);
    assign o_out_result = r_result;
    assign o_out_ovf    = r_ovf;
    assign o_out_unf    = r_unf;
    assign o_out_inx    = r_inx;

endmodule

// File: tb/tb_fp16_result_packer.sv
// Directed bench for fp16_result_packer with hand-computed expected values.
module tb_fp16_result_packer;

    logic        i_clk = 1'b0;
    logic        i_clr = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        i_in_sign = 1'b0;
    logic [6:0]  i_in_exp = '0;
    logic [13:0] i_in_mant = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [15:0] o_out_result;
    logic        o_out_ovf;
    logic        o_out_unf;
    logic        o_out_inx;

    int n_checks = 0;
    int n_pass   = 0;

    fp16_result_packer dut (
        .i_clk        (i_clk),
        .i_clr        (i_clr),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_sign    (i_in_sign),
        .i_in_exp     (i_in_exp),
        .i_in_mant    (i_in_mant),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_result (o_out_result),
        .o_out_ovf    (o_out_ovf),
        .o_out_unf    (o_out_unf),
        .o_out_inx    (o_out_inx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Present one operand; returns just after the accepting edge.
    task automatic start_op(input logic s, input logic [6:0] e, input logic [13:0] m);
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_sign  = s;
        i_in_exp   = e;
        i_in_mant  = m;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge up to the one raising OUT_VALID.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 1;
        while (!o_out_valid && lat < 40) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check({tag, " valid"}, {31'd0, o_out_valid}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic check_out(input string tag, input logic [15:0] res,
                             input logic ovf, input logic unf, input logic inx);
        check({tag, " result"}, {16'd0, o_out_result}, {16'd0, res});
        check({tag, " flags"}, {29'd0, o_out_ovf, o_out_unf, o_out_inx},
              {29'd0, ovf, unf, inx});
    endtask

    task automatic finish_op(input string tag);
        @(negedge i_clk);
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        check({tag, " drop"}, {30'd0, o_out_valid, o_in_ready}, 32'b01);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [6:0] e,
                          input logic [13:0] m, input logic [15:0] res, input logic ovf,
                          input logic unf, input logic inx, input int lat);
        start_op(s, e, m);
        wait_done(tag, lat);
        check_out(tag, res, ovf, unf, inx);
        finish_op(tag);
    endtask

    initial begin
        #1;
        check("reset ready", {31'd0, o_in_ready}, 32'd1);
        check("reset valid", {31'd0, o_out_valid}, 32'd0);
        check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        #11;
        i_clr = 1'b0;

        run_op("one",      1'b0, 7'd15,  14'h1000, 16'h3C00, 1'b0, 1'b0, 1'b0, 3);
        run_op("neg_one",  1'b1, 7'd15,  14'h1000, 16'hBC00, 1'b0, 1'b0, 1'b0, 3);
        run_op("rshift",   1'b0, 7'd15,  14'h2000, 16'h4000, 1'b0, 1'b0, 1'b0, 4);
        run_op("lshift2",  1'b0, 7'd15,  14'h0400, 16'h3400, 1'b0, 1'b0, 1'b0, 5);
        run_op("tie_up",   1'b0, 7'd15,  14'h1006, 16'h3C02, 1'b0, 1'b0, 1'b1, 3);
        run_op("tie_even", 1'b0, 7'd15,  14'h1002, 16'h3C00, 1'b0, 1'b0, 1'b1, 3);
        run_op("rnd_ovf",  1'b0, 7'd30,  14'h1FFE, 16'h7C00, 1'b1, 1'b0, 1'b1, 3);
        run_op("big_exp",  1'b0, 7'd40,  14'h1000, 16'h7C00, 1'b1, 1'b0, 1'b1, 3);
        run_op("sub_ex",   1'b0, 7'd0,   14'h1000, 16'h0200, 1'b0, 1'b0, 1'b0, 4);
        run_op("sub_inx",  1'b0, 7'd0,   14'h1001, 16'h0200, 1'b0, 1'b1, 1'b1, 4);
        run_op("neg_zero", 1'b1, 7'd15,  14'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 3);
        run_op("sub2norm", 1'b0, 7'd1,   14'h0FFE, 16'h0400, 1'b0, 1'b1, 1'b1, 3);
        run_op("neg_exp",  1'b0, 7'h7D,  14'h1000, 16'h0040, 1'b0, 1'b0, 1'b0, 7);

        // Back-pressure: result and flags hold, new input is ignored.
        start_op(1'b0, 7'd15, 14'h1006);
        wait_done("hold", 3);
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_mant  = 14'h2000;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check("hold result", {16'd0, o_out_result}, 32'h3C02);
            check("hold state", {30'd0, o_out_valid, o_in_ready}, 32'b10);
        end
        i_in_valid = 1'b0;
        check_out("hold end", 16'h3C02, 1'b0, 1'b0, 1'b1);
        finish_op("hold");

        // Asynchronous clear during a long left-shift sequence.
        start_op(1'b0, 7'd15, 14'h0004);
        @(posedge i_clk);
        #2;
        check("clr busy", {31'd0, o_in_ready}, 32'd0);
        i_clr = 1'b1;
        #1;
        check("clr async", {30'd0, o_out_valid, o_in_ready}, 32'b01);
        @(posedge i_clk);
        #1;
        i_clr = 1'b0;
        check("clr next", {30'd0, o_out_valid, o_in_ready}, 32'b01);
        check_out("clr", 16'h0000, 1'b0, 1'b0, 1'b0);

        run_op("recover",  1'b0, 7'd15,  14'h2000, 16'h4000, 1'b0, 1'b0, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
